// File: rtl/pipe_skid_reg_if.sv
// Handshake bundle for pipe_skid_reg: upstream valid/ready/data in, downstream valid/ready/data out.
// The stage itself uses the slave modport; whatever feeds and drains it uses master.
interface pipe_skid_reg_if #(
  parameter int WIDTH = 101
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register, optionally a two-entry skid buffer with a registered in_ready.
// Define PIPE_SKID_PERF_CNT_EN to build the saturating stall/bubble counters in.
module pipe_skid_reg #(
  parameter int WIDTH = 101,
  parameter int SKID  = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_skid_reg_if.slave   bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             main_load, skid_load, main_from_skid;
  logic             in_ready_w, in_fire, out_fire;

  // SKID=1 breaks the out_ready -> in_ready path with a flop; SKID=0 passes it straight through.
  assign in_ready_w = (SKID != 0) ? in_ready_q : (!main_valid_q || bus.out_ready);
  assign in_fire    = bus.in_valid && in_ready_w;
  assign out_fire   = main_valid_q && bus.out_ready;

  always_comb begin
    main_valid_d   = main_valid_q;
    skid_valid_d   = skid_valid_q;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (SKID != 0) begin
      if (!main_valid_q) begin
        if (in_fire) begin
          main_load    = 1'b1;
          main_valid_d = 1'b1;
        end
      end else if (out_fire) begin
        if (skid_valid_q) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_valid_d   = 1'b0;
        end else if (in_fire) begin
          main_load = 1'b1;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (in_fire) begin
        skid_load    = 1'b1;
        skid_valid_d = 1'b1;
      end
    end else begin
      if (in_fire) begin
        main_load    = 1'b1;
        main_valid_d = 1'b1;
      end else if (out_fire) begin
        main_valid_d = 1'b0;
      end
    end
  end

  assign main_data_d = main_from_skid ? skid_data_q : bus.in_data;
  assign skid_data_d = bus.in_data;
  assign in_ready_d  = !skid_valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  // Payload flops carry no reset; the valid bits alone decide what the data means.
  always_ff @(posedge clk) begin
    if (main_load) main_data_q <= main_data_d;
    if (skid_load) skid_data_q <= skid_data_d;
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = main_valid_q;
  assign bus.out_data  = main_valid_q ? main_data_q : '0;
  assign occupancy     = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

`ifdef PIPE_SKID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating counters; flush deliberately leaves them alone.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_valid_q && !bus.out_ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (!main_valid_q && bus.out_ready && (bubble_cnt_q != '1))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
